// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared pipeline constants and tag types for the forwarding/hazard unit
package fwd_hazard_unit_pkg;

  localparam int MAX_ADDR_W = 8;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [MAX_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] wr;
    logic                  regwrite;
    logic                  memread;
  } tag_t;

  // Past EX nothing cares whether the producer was a load.
  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] wr;
    logic                  regwrite;
  } mtag_t;

  function automatic logic is_writing(input logic valid, input logic [MAX_ADDR_W-1:0] wr,
                                      input logic regwrite);
    return valid && regwrite && (wr != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - ID-stage request and stall/forward response bundle
interface fwd_hazard_unit_if #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2
);
  logic                      id_valid;
  logic [NUM_SRC*ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [ADDR_W-1:0]         id_wr;
  logic                      id_regwrite;
  logic                      id_memread;
  logic                      flush;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble;

  modport master (
    output id_valid, id_src, id_src_used, id_wr, id_regwrite, id_memread, flush,
    input  fwd_sel, stall, bubble
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_wr, id_regwrite, id_memread, flush,
    output fwd_sel, stall, bubble
  );
endinterface

// File: rtl/fwd_hazard_unit_fwd_cmp.sv
// rtl/fwd_hazard_unit_fwd_cmp.sv - per-operand forward select and load-use detect
module fwd_cmp
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              used,
  input  logic              id_valid,
  input  tag_t              ex_t,
  input  mtag_t             mem_t,
  output logic [1:0]        sel,
  output logic              hazard
);
  logic [MAX_ADDR_W-1:0] src_x;
  logic                  ex_hit;
  logic                  mem_hit;

  always_comb begin
    src_x   = MAX_ADDR_W'(src);
    ex_hit  = used && is_writing(ex_t.valid, ex_t.wr, ex_t.regwrite) && (ex_t.wr == src_x);
    mem_hit = used && is_writing(mem_t.valid, mem_t.wr, mem_t.regwrite) && (mem_t.wr == src_x);
    sel     = FWD_RF;
    // Younger producer wins; a non-writing EX entry never masks MEM.
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
    hazard = id_valid && ex_hit && ex_t.memread;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding selects and load-use stall control for a 5-stage pipeline
// Tracks EX/MEM destination tags and registers per-operand selects for the instruction entering EX.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  fwd_hazard_unit_if.slave bus
);
  localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOAD_LAT - 1);

  tag_t                 ex_q, ex_d, id_tag;
  mtag_t                mem_q, mem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SRC*2-1:0] fwd_q, fwd_d, sel_vec;
  logic [NUM_SRC-1:0]   haz_vec;
  logic                 hazard, stall, bubble;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_op
    fwd_cmp #(.ADDR_W(ADDR_W)) u_cmp (
      .src      (bus.id_src[k*ADDR_W +: ADDR_W]),
      .used     (bus.id_src_used[k]),
      .id_valid (bus.id_valid),
      .ex_t     (ex_q),
      .mem_t    (mem_q),
      .sel      (sel_vec[2*k +: 2]),
      .hazard   (haz_vec[k])
    );
  end

  // A WB-stage tag would be dead state: the MEM/WB select is registered from mem_q a cycle early.
  always_comb begin
    id_tag          = '0;
    id_tag.valid    = bus.id_valid;
    id_tag.wr       = MAX_ADDR_W'(bus.id_wr);
    id_tag.regwrite = bus.id_regwrite;
    id_tag.memread  = bus.id_memread;

    hazard = |haz_vec;
    stall  = !bus.flush && ((cnt_q != '0) || hazard);
    bubble = stall || bus.flush;

    cnt_d = cnt_q;
    if (bus.flush) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (hazard) begin
      cnt_d = CNT_RELOAD;
    end

    ex_d           = bubble ? '0 : id_tag;
    mem_d          = '0;
    mem_d.valid    = ex_q.valid;
    mem_d.wr       = ex_q.wr;
    mem_d.regwrite = ex_q.regwrite;
    fwd_d          = bubble ? '0 : sel_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      cnt_q <= '0;
      fwd_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      fwd_q <= fwd_d;
    end
  end

  assign bus.fwd_sel = fwd_q;
  assign bus.stall   = stall;
  assign bus.bubble  = bubble;
endmodule
